// File: rtl/io_port.sv
// CPU-side I/O responder: iow bytes queue in a TX FIFO toward the device; device bytes queue in an RX FIFO for ior.
// Optional build macro IO_LOOPBACK_EN adds a loop input that routes the TX head straight into the RX FIFO.
module io_port #(
  parameter int TXDEPTH = 4,
  parameter int RXDEPTH = 4
) (
  input  logic       clk,
  input  logic       nclr,
  input  logic       iow,
  input  logic       ior,
  input  logic [7:0] ioout,
  output logic [7:0] iodata,
  input  logic       ienabled,
  input  logic       istatus,
  output logic       irq,
  output logic       txovf,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready
`ifdef IO_LOOPBACK_EN
  ,
  input  logic       loop
`endif
);

  localparam int TXAW = (TXDEPTH > 1) ? $clog2(TXDEPTH) : 1;
  localparam int RXAW = (RXDEPTH > 1) ? $clog2(RXDEPTH) : 1;
  localparam int TXCW = TXAW + 1;
  localparam int RXCW = RXAW + 1;

  logic [7:0]      tx_mem_q [TXDEPTH];
  logic [7:0]      rx_mem_q [RXDEPTH];
  logic [TXAW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [RXAW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [TXCW-1:0] tx_cnt_q, tx_cnt_d;
  logic [RXCW-1:0] rx_cnt_q, rx_cnt_d;
  logic            irq_q, irq_d;
  logic            txovf_q, txovf_d;

  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic       tx_push, tx_pop, rx_push, rx_pop;
  logic       loop_on;
  logic       rx_in_valid;
  logic [7:0] rx_in_data;
  logic [7:0] tx_head;

`ifdef IO_LOOPBACK_EN
  assign loop_on = loop;
`else
  assign loop_on = 1'b0;
`endif

  assign tx_full  = (tx_cnt_q == TXCW'(TXDEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == RXCW'(RXDEPTH));
  assign rx_empty = (rx_cnt_q == '0);
  assign tx_head  = tx_mem_q[tx_rp_q];

  // In loopback the RX FIFO's free space takes the place of tx_ready.
  assign rx_in_valid = loop_on ? !tx_empty : rx_valid;
  assign rx_in_data  = loop_on ? tx_head   : rx_data;

  assign tx_push = iow & !tx_full;
  assign tx_pop  = !tx_empty & (loop_on ? !rx_full : tx_ready);
  assign rx_push = rx_in_valid & !rx_full;
  assign rx_pop  = ior & !rx_empty;

  assign tx_valid = !tx_empty & !loop_on;
  assign tx_data  = tx_head;
  assign rx_ready = !rx_full & !loop_on;
  assign iodata   = rx_empty ? 8'h00 : rx_mem_q[rx_rp_q];
  assign irq      = irq_q;
  assign txovf    = txovf_q;

  always_comb begin
    tx_wp_d  = tx_push ? tx_wp_q + TXAW'(1) : tx_wp_q;
    tx_rp_d  = tx_pop  ? tx_rp_q + TXAW'(1) : tx_rp_q;
    rx_wp_d  = rx_push ? rx_wp_q + RXAW'(1) : rx_wp_q;
    rx_rp_d  = rx_pop  ? rx_rp_q + RXAW'(1) : rx_rp_q;
    tx_cnt_d = tx_cnt_q;
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + TXCW'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - TXCW'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase
    rx_cnt_d = rx_cnt_q;
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + RXCW'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - RXCW'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase
    txovf_d = txovf_q | (iow & tx_full);
    irq_d   = !rx_empty & ienabled & !istatus;
  end

  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      irq_q    <= 1'b0;
      txovf_q  <= 1'b0;
    end else begin
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      irq_q    <= irq_d;
      txovf_q  <= txovf_d;
    end
  end

  // Storage needs no reset: pointers and counts alone define what is valid.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= ioout;
    if (rx_push) rx_mem_q[rx_wp_q] <= rx_in_data;
  end

endmodule

// File: tb/tb_io_port.sv
// Directed bench for io_port: a queue-based model checked every cycle, plus hand-computed literal checks.
module tb_io_port;
  localparam int TXD = 4;
  localparam int RXD = 4;

  logic       clk = 1'b0;
  logic       nclr = 1'b0;
  logic       iow = 1'b0, ior = 1'b0;
  logic [7:0] ioout = 8'h00, rx_data = 8'h00;
  logic       ienabled = 1'b0, istatus = 1'b0;
  logic       tx_ready = 1'b0, rx_valid = 1'b0;
  logic       loop = 1'b0;
  logic [7:0] iodata, tx_data;
  logic       irq, txovf, tx_valid, rx_ready;

  int errors = 0;
  int checks = 0;

  io_port #(.TXDEPTH(TXD), .RXDEPTH(RXD)) dut (
    .clk(clk), .nclr(nclr), .iow(iow), .ior(ior), .ioout(ioout), .iodata(iodata),
    .ienabled(ienabled), .istatus(istatus), .irq(irq), .txovf(txovf),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
`ifdef IO_LOOPBACK_EN
    , .loop(loop)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queues updated with the pre-edge rules.
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic       irq_m = 1'b0, ovf_m = 1'b0;
  bit         m_txpop, m_rxpush, m_rxpop, m_txfull, m_loop;
  logic [7:0] m_rxin;

  always @(negedge nclr) begin
    tx_q.delete();
    rx_q.delete();
    irq_m = 1'b0;
    ovf_m = 1'b0;
  end

  always @(posedge clk) begin
    if (nclr) begin
`ifdef IO_LOOPBACK_EN
      m_loop = loop;
`else
      m_loop = 1'b0;
`endif
      m_txfull = (tx_q.size() == TXD);
      m_txpop  = (tx_q.size() > 0) && (m_loop ? (rx_q.size() < RXD) : tx_ready);
      m_rxin   = m_loop ? ((tx_q.size() > 0) ? tx_q[0] : 8'h00) : rx_data;
      m_rxpush = (m_loop ? (tx_q.size() > 0) : rx_valid) && (rx_q.size() < RXD);
      m_rxpop  = ior && (rx_q.size() > 0);
      irq_m    = (rx_q.size() != 0) && ienabled && !istatus;
      if (m_rxpop) void'(rx_q.pop_front());
      if (m_rxpush) rx_q.push_back(m_rxin);
      if (m_txpop) void'(tx_q.pop_front());
      if (iow && !m_txfull) tx_q.push_back(ioout);
      else if (iow) ovf_m = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (nclr) begin
      chk("m_tx_valid", {7'd0, tx_valid}, {7'd0, (tx_q.size() > 0) && !m_loop_now()});
      if (tx_q.size() > 0 && !m_loop_now()) chk("m_tx_data", tx_data, tx_q[0]);
      chk("m_rx_ready", {7'd0, rx_ready}, {7'd0, (rx_q.size() < RXD) && !m_loop_now()});
      chk("m_iodata", iodata, (rx_q.size() > 0) ? rx_q[0] : 8'h00);
      chk("m_irq", {7'd0, irq}, {7'd0, irq_m});
      chk("m_txovf", {7'd0, txovf}, {7'd0, ovf_m});
    end
  end

  function automatic bit m_loop_now();
`ifdef IO_LOOPBACK_EN
    return loop;
`else
    return 1'b0;
`endif
  endfunction

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] txv [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    #2;
    chk("rst_tx_valid", {7'd0, tx_valid}, 8'h00);
    chk("rst_rx_ready", {7'd0, rx_ready}, 8'h01);
    chk("rst_iodata", iodata, 8'h00);
    #20 nclr = 1'b1;
    cyc();

    // TX fill, overflow, drain
    for (int i = 0; i < 4; i++) begin
      iow = 1'b1; ioout = txv[i]; cyc();
      $display("iow %02h tx_valid=%0b tx_data=%02h", txv[i], tx_valid, tx_data);
    end
    iow = 1'b0;
    chk("tx_valid_full", {7'd0, tx_valid}, 8'h01);
    chk("tx_head", tx_data, 8'h11);
    chk("txovf_pre", {7'd0, txovf}, 8'h00);
    iow = 1'b1; ioout = 8'h55; cyc(); iow = 1'b0;
    chk("txovf_set", {7'd0, txovf}, 8'h01);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      $display("tx drain %0d data=%02h", i, tx_data);
      chk("tx_drain", tx_data, txv[i]);
      cyc();
    end
    chk("tx_empty_no55", {7'd0, tx_valid}, 8'h00);
    // push and pop in one cycle with ready held
    iow = 1'b1; ioout = 8'h66; cyc(); ioout = 8'h67; cyc(); iow = 1'b0;
    chk("tx_stream", tx_data, 8'h67);
    cyc();
    tx_ready = 1'b0;

    // single RX byte and irq timing
    ienabled = 1'b1;
    rx_valid = 1'b1; rx_data = 8'hA5; cyc(); rx_valid = 1'b0;
    $display("rx A5 iodata=%02h irq=%0b", iodata, irq);
    chk("rx_head", iodata, 8'hA5);
    chk("irq_latency0", {7'd0, irq}, 8'h00);
    cyc();
    chk("irq_up", {7'd0, irq}, 8'h01);
    ior = 1'b1; cyc(); ior = 1'b0;
    chk("rx_popped", iodata, 8'h00);
    chk("irq_hold", {7'd0, irq}, 8'h01);
    cyc();
    chk("irq_down", {7'd0, irq}, 8'h00);

    // RX fill, pop while full with rx_valid
    for (int i = 1; i <= 4; i++) begin
      rx_valid = 1'b1; rx_data = 8'(i); cyc();
    end
    rx_valid = 1'b0;
    chk("rx_full", {7'd0, rx_ready}, 8'h00);
    ior = 1'b1; rx_valid = 1'b1; rx_data = 8'h05; cyc();
    ior = 1'b0; rx_valid = 1'b0;
    chk("rx_ready_back", {7'd0, rx_ready}, 8'h01);
    for (int i = 2; i <= 4; i++) begin
      $display("ior iodata=%02h", iodata);
      chk("rx_order", iodata, 8'(i));
      ior = 1'b1; cyc(); ior = 1'b0;
    end
    chk("rx_drained", iodata, 8'h00);
    // push into empty with same-cycle ior
    ior = 1'b1; rx_valid = 1'b1; rx_data = 8'h9C; cyc();
    ior = 1'b0; rx_valid = 1'b0;
    chk("push_only", iodata, 8'h9C);

    // irq gating
    ienabled = 1'b0; cyc(); cyc();
    chk("irq_disabled", {7'd0, irq}, 8'h00);
    ienabled = 1'b1; istatus = 1'b1; cyc(); cyc();
    chk("irq_servicing", {7'd0, irq}, 8'h00);
    istatus = 1'b0; cyc();
    chk("irq_resume", {7'd0, irq}, 8'h01);

`ifdef IO_LOOPBACK_EN
    ior = 1'b1; cyc(); ior = 1'b0; cyc();
    loop = 1'b1;
    iow = 1'b1; ioout = 8'h3C; cyc(); iow = 1'b0;
    chk("lb_tx_valid", {7'd0, tx_valid}, 8'h00);
    cyc();
    chk("lb_iodata", iodata, 8'h3C);
    chk("lb_rx_ready", {7'd0, rx_ready}, 8'h00);
    ior = 1'b1; cyc(); ior = 1'b0;
    loop = 1'b0;
`endif

    // reset mid-traffic
    iow = 1'b1; ioout = 8'h77; cyc(); iow = 1'b0;
    rx_valid = 1'b1; rx_data = 8'h42;
    #2 nclr = 1'b0;
    #1;
    $display("reset tx_valid=%0b rx_ready=%0b irq=%0b txovf=%0b iodata=%02h",
             tx_valid, rx_ready, irq, txovf, iodata);
    chk("mr_tx_valid", {7'd0, tx_valid}, 8'h00);
    chk("mr_rx_ready", {7'd0, rx_ready}, 8'h01);
    chk("mr_irq", {7'd0, irq}, 8'h00);
    chk("mr_txovf", {7'd0, txovf}, 8'h00);
    chk("mr_iodata", iodata, 8'h00);
    rx_valid = 1'b0;
    cyc();
    nclr = 1'b1;
    cyc(); cyc();
    chk("post_rst_empty", {7'd0, tx_valid}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
